gamepad_pmod_transmitter: RTL and testbench



---
 rtl/gamepad_pmod_transmitter.sv | 151 +++++++++++++++
 tb/tb_gamepad_pmod_transmitter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_transmitter.sv
// Gamepad Pmod serial transmitter: shifts a parallel button word out MSB-first
// as pmod_clk / pmod_data, then a pmod_latch pulse, then an idle gap.
// All outputs come straight from flops.
//
// state | meaning
// IDLE  | waiting for enable, all outputs low
// SETUP | pmod_clk low, current bit on pmod_data
// HIGH  | pmod_clk high, receiver samples current bit
// LATCH | pmod_latch high after the last bit
// GAP   | idle clocks before the next frame (busy still high)
module gamepad_pmod_transmitter #(
  parameter int BIT_WIDTH  = 12,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [BIT_WIDTH-1:0] tx_data,
  output logic                 pmod_clk,
  output logic                 pmod_data,
  output logic                 pmod_latch,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DIV_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_W   = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LOAD = DIV_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BIT_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LATCH = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [BIT_WIDTH-1:0] shift, shift_nxt;
  logic [DIV_W-1:0]     div_cnt, div_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic                 clk_nxt, data_nxt, latch_nxt, busy_nxt, done_nxt;
  logic                 cnt_done, load;

  assign cnt_done = (div_cnt == '0);
  // A frame loads from IDLE or at the end of the gap when enable is still high.
  assign load = enable && ((state == IDLE) || ((state == GAP) && cnt_done));

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      pmod_clk   <= 1'b0;
      pmod_data  <= 1'b0;
      pmod_latch <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      pmod_clk   <= clk_nxt;
      pmod_data  <= data_nxt;
      pmod_latch <= latch_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next-state selection; every timed state leaves when its down-counter hits zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable)   state_nxt = SETUP;
      SETUP: if (cnt_done) state_nxt = HIGH;
      HIGH:  if (cnt_done) state_nxt = (bit_cnt == LAST_BIT) ? LATCH : SETUP;
      LATCH: if (cnt_done) state_nxt = GAP;
      GAP:   if (cnt_done) state_nxt = enable ? SETUP : IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, shifter and counters.
  always_comb begin
    shift_nxt = shift;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    clk_nxt   = pmod_clk;
    data_nxt  = pmod_data;
    latch_nxt = pmod_latch;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    if (state != IDLE && !cnt_done) div_nxt = div_cnt - DIV_W'(1);

    case (state)
      SETUP: begin
        if (cnt_done) begin
          clk_nxt = 1'b1;
          div_nxt = DIV_LOAD;
        end
      end
      HIGH: begin
        if (cnt_done) begin
          clk_nxt = 1'b0;
          div_nxt = DIV_LOAD;
          if (bit_cnt == LAST_BIT) begin
            data_nxt  = 1'b0;
            latch_nxt = 1'b1;
          end else begin
            // Data only moves on the pmod_clk falling edge.
            shift_nxt = shift << 1;
            data_nxt  = shift_nxt[BIT_WIDTH-1];
            bit_nxt   = bit_cnt + BIT_W'(1);
          end
        end
      end
      LATCH: begin
        if (cnt_done) begin
          latch_nxt = 1'b0;
          done_nxt  = 1'b1;
          div_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_done && !enable) busy_nxt = 1'b0;
      end
      default: ;
    endcase

    // Snapshot of tx_data; later changes wait for the next frame.
    if (load) begin
      shift_nxt = tx_data;
      data_nxt  = tx_data[BIT_WIDTH-1];
      busy_nxt  = 1'b1;
      bit_nxt   = '0;
      div_nxt   = DIV_LOAD;
      clk_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_transmitter.sv
// Bench for gamepad_pmod_transmitter: a frame-offset timing model checked every
// cycle, a behavioural receiver for loopback, and directed timing checks.
module tb_gamepad_pmod_transmitter;

  localparam int DIV = 4;
  localparam int GAP = 8;
  localparam int P_A = 2 * DIV * 12 + DIV + GAP;
  localparam int P_B = 2 * DIV * 24 + DIV + GAP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [11:0] tx_a;
  logic [23:0] tx_b;
  logic        pclk_a, pdata_a, plat_a, busy_a, fd_a;
  logic        pclk_b, pdata_b, plat_b, busy_b, fd_b;

  gamepad_pmod_transmitter #(.BIT_WIDTH(12), .CLK_DIV(DIV), .GAP_CYCLES(GAP)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .tx_data(tx_a),
    .pmod_clk(pclk_a), .pmod_data(pdata_a), .pmod_latch(plat_a),
    .busy(busy_a), .frame_done(fd_a)
  );

  gamepad_pmod_transmitter #(.BIT_WIDTH(24), .CLK_DIV(DIV), .GAP_CYCLES(GAP)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .tx_data(tx_b),
    .pmod_clk(pclk_b), .pmod_data(pdata_b), .pmod_latch(plat_b),
    .busy(busy_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;

  // Behavioural receivers: sample on pmod_clk rise, transfer on latch rise.
  logic [11:0] rx_sh_a = '0, rx_reg_a = '0;
  logic [23:0] rx_sh_b = '0, rx_reg_b = '0;
  always @(posedge pclk_a) rx_sh_a <= {rx_sh_a[10:0], pdata_a};
  always @(posedge plat_a) rx_reg_a <= rx_sh_a;
  always @(posedge pclk_b) rx_sh_b <= {rx_sh_b[22:0], pdata_b};
  always @(posedge plat_b) rx_reg_b <= rx_sh_b;

  // Frame model: offset k within the frame plus the word captured at load.
  logic        ma_act, mb_act;
  int          ma_k, mb_k;
  logic [23:0] ma_w, mb_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_act <= 1'b0; ma_k <= 0; ma_w <= '0;
    end else if (!ma_act) begin
      if (en_a) begin ma_act <= 1'b1; ma_k <= 0; ma_w <= {12'h000, tx_a}; end
    end else if (ma_k == P_A - 1) begin
      if (en_a) begin ma_k <= 0; ma_w <= {12'h000, tx_a}; end
      else ma_act <= 1'b0;
    end else ma_k <= ma_k + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_act <= 1'b0; mb_k <= 0; mb_w <= '0;
    end else if (!mb_act) begin
      if (en_b) begin mb_act <= 1'b1; mb_k <= 0; mb_w <= tx_b; end
    end else if (mb_k == P_B - 1) begin
      if (en_b) begin mb_k <= 0; mb_w <= tx_b; end
      else mb_act <= 1'b0;
    end else mb_k <= mb_k + 1;
  end

  // Expected {pmod_clk, pmod_data, pmod_latch, busy, frame_done} at frame offset k.
  function automatic logic [4:0] expect_out(input logic act, input int k,
                                            input logic [23:0] w, input int width);
    int n;
    if (!act) return 5'b00000;
    if (k < 2 * DIV * width) begin
      n = k / (2 * DIV);
      return {((k % (2 * DIV)) >= DIV), w[width - 1 - n], 1'b0, 1'b1, 1'b0};
    end
    if (k < 2 * DIV * width + DIV) return 5'b00110;
    if (k == 2 * DIV * width + DIV) return 5'b00011;
    return 5'b00010;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Event trackers for directed timing checks.
  int t_a, tfall_a, tfd_a, tfd_prev_a, lat_rise_a, edges_a, bad_edge_a, lat_cnt_a, fd_cnt_a;
  int t_b, tfall_b;
  logic pbusy_a = 1'b0, ppclk_a = 1'b0, pplat_a = 1'b0, pbusy_b = 1'b0;

  task automatic clear_a();
    edges_a = 0; bad_edge_a = 0; lat_cnt_a = 0; fd_cnt_a = 0; lat_rise_a = -1;
  endtask

  // One cycle: advance to the falling edge, compare both DUTs to the model, track events.
  task automatic step();
    @(negedge clk);
    ncyc++;
    if (rst_n) begin
      chk("cycle_a", 32'({pclk_a, pdata_a, plat_a, busy_a, fd_a}),
          32'(expect_out(ma_act, ma_k, ma_w, 12)));
      chk("cycle_b", 32'({pclk_b, pdata_b, plat_b, busy_b, fd_b}),
          32'(expect_out(mb_act, mb_k, mb_w, 24)));
    end
    if (busy_a && !pbusy_a) t_a = ncyc;
    if (!busy_a && pbusy_a) tfall_a = ncyc;
    if (pclk_a && !ppclk_a) begin
      edges_a++;
      if (((ncyc - t_a) % (2 * DIV)) != DIV) bad_edge_a++;
    end
    if (plat_a && !pplat_a) lat_rise_a = ncyc;
    if (plat_a) lat_cnt_a++;
    if (fd_a) begin fd_cnt_a++; tfd_prev_a = tfd_a; tfd_a = ncyc; end
    if (busy_b && !pbusy_b) t_b = ncyc;
    if (!busy_b && pbusy_b) tfall_b = ncyc;
    pbusy_a = busy_a; ppclk_a = pclk_a; pplat_a = plat_a; pbusy_b = busy_b;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while (busy_a && n < budget) begin step(); n++; end
    if (busy_a) begin
      tests++; fails++;
      $display("FAIL timeout_a: busy still 1 after %0d cycles, want 0", budget);
    end
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    while (busy_b && n < budget) begin step(); n++; end
    if (busy_b) begin
      tests++; fails++;
      $display("FAIL timeout_b: busy still 1 after %0d cycles, want 0", budget);
    end
  endtask

  task automatic wait_fd_a(input int budget);
    int n = 0;
    int start = fd_cnt_a;
    while (fd_cnt_a == start && n < budget) begin step(); n++; end
    if (fd_cnt_a == start) begin
      tests++; fails++;
      $display("FAIL timeout_fd: no frame_done after %0d cycles, want a pulse", budget);
    end
  endtask

  task automatic pulse_a(input logic [11:0] w);
    tx_a = w; en_a = 1'b1; clear_a(); step(); en_a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; tx_a = '0; tx_b = '0;
    t_a = 0; tfall_a = 0; tfd_a = 0; tfd_prev_a = 0; t_b = 0; tfall_b = 0;
    clear_a();
    step(); step();
    chk("reset_a", 32'({pclk_a, pdata_a, plat_a, busy_a, fd_a}), 32'd0);
    chk("reset_b", 32'({pclk_b, pdata_b, plat_b, busy_b, fd_b}), 32'd0);
    rst_n = 1'b1;
    step(); step();

    // Single frame of 12'h880: b and up pressed.
    pulse_a(12'h880);
    wait_idle_a(300);
    chk("t1_rx_word", 32'(rx_reg_a), 32'h880);
    chk("t1_b",       32'(rx_reg_a[11]), 32'd1);
    chk("t1_up",      32'(rx_reg_a[7]), 32'd1);
    chk("t1_edges",   32'(edges_a), 32'd12);
    chk("t1_edge_pos", 32'(bad_edge_a), 32'd0);
    chk("t1_latch_at", 32'(lat_rise_a - t_a), 32'd96);
    chk("t1_latch_len", 32'(lat_cnt_a), 32'd4);
    chk("t1_fd_count", 32'(fd_cnt_a), 32'd1);
    chk("t1_fd_at",   32'(tfd_a - t_a), 32'd100);
    chk("t1_busy_fall", 32'(tfall_a - t_a), 32'd108);

    // Enable held, tx_data changed mid-frame.
    tx_a = 12'h001; en_a = 1'b1; clear_a(); step();
    while (ncyc < t_a + 40) step();
    tx_a = 12'h002;
    wait_fd_a(200);
    chk("t2_rx_first", 32'(rx_reg_a), 32'h001);
    chk("t2_fd_at",    32'(tfd_a - t_a), 32'd100);
    wait_fd_a(200);
    chk("t2_rx_second", 32'(rx_reg_a), 32'h002);
    chk("t2_period",   32'(tfd_a - tfd_prev_a), 32'd108);
    en_a = 1'b0;
    wait_idle_a(300);
    chk("t2_busy_fall", 32'(tfall_a - t_a), 32'd216);
    chk("t2_edges",    32'(edges_a), 32'd24);

    // Enable dropped early: frame still completes in full.
    tx_a = 12'h0F0; en_a = 1'b1; clear_a(); step();
    while (ncyc < t_a + 10) step();
    en_a = 1'b0;
    wait_idle_a(300);
    chk("t3_fd_at",    32'(tfd_a - t_a), 32'd100);
    chk("t3_busy_fall", 32'(tfall_a - t_a), 32'd108);
    chk("t3_rx",       32'(rx_reg_a), 32'h0F0);
    repeat (30) step();
    chk("t3_no_more_edges", 32'(edges_a), 32'd12);
    chk("t3_idle_busy", 32'(busy_a), 32'd0);

    // Reset inside HIGH of bit 3: outputs clear at once, receiver keeps old word.
    pulse_a(12'h880);
    wait_idle_a(300);
    chk("t4_rx_before", 32'(rx_reg_a), 32'h880);
    pulse_a(12'h5A5);
    while (ncyc < t_a + 30) step();
    chk("t4_clk_high", 32'(pclk_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_outs_zero", 32'({pclk_a, pdata_a, plat_a, busy_a, fd_a}), 32'd0);
    chk("t4_rx_kept",  32'(rx_reg_a), 32'h880);
    step(); step();
    rst_n = 1'b1;
    step();
    pulse_a(12'h5A5);
    wait_idle_a(300);
    chk("t4_rx_fresh", 32'(rx_reg_a), 32'h5A5);

    // Dual-controller frame.
    tx_b = 24'h000800; en_b = 1'b1; step(); en_b = 1'b0;
    wait_idle_b(400);
    chk("t5_rx_word", 32'(rx_reg_b), 32'h000800);
    chk("t5_c1_b",    32'(rx_reg_b[11]), 32'd1);
    chk("t5_c2_none", 32'(rx_reg_b[23:12]), 32'd0);
    chk("t5_period",  32'(tfall_b - t_b), 32'd204);
    tx_b = 24'hABC123; en_b = 1'b1; step(); en_b = 1'b0;
    wait_idle_b(400);
    chk("t5_rx_word2", 32'(rx_reg_b), 32'hABC123);

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
